// File: rtl/mem_stream_reader_if.sv
// Bundle of the burst-control, memory-read and output-stream signals of
// mem_stream_reader. The master modport is the reader's view and the slave
// modport is the view of the surrounding logic (requester, memory, consumer).
interface mem_stream_reader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  // Burst control
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  busy;
  logic                  done;
  // Memory read port (one-cycle read latency)
  logic                  mem_r_en;
  logic [ADDR_WIDTH-1:0] mem_r_addr;
  logic [DATA_WIDTH-1:0] mem_r_data;
  // Output stream
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  start, base_addr, count, mem_r_data, m_ready,
    output busy, done, mem_r_en, mem_r_addr, m_data, m_valid
  );

  modport slave (
    output start, base_addr, count, mem_r_data, m_ready,
    input  busy, done, mem_r_en, mem_r_addr, m_data, m_valid
  );
endinterface

// File: rtl/mem_stream_reader.sv
// Reads a burst of consecutive words from a one-cycle-latency memory and
// streams them out through a two-entry FIFO with valid/ready flow control.
// Addresses wrap modulo 2^ADDR_WIDTH; bursts longer than the memory are
// clamped to one full pass. Reads are throttled so that the words already
// buffered plus the read in flight never exceed the FIFO depth.
module mem_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stream_reader_if.master  bus
);

  localparam logic [ADDR_WIDTH:0]   MAX_COUNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   ONE_COUNT = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  done_q, done_d;
  logic                  rd_pending_q;

  // Two-entry output FIFO: head drives the stream, tail holds the spare word
  logic                  head_valid_q, tail_valid_q;
  logic [DATA_WIDTH-1:0] head_data_q, tail_data_q;

  logic                  rd_en;
  logic                  pop;
  logic                  push;
  logic                  last_pop;
  logic [1:0]            occ_next;
  logic [ADDR_WIDTH:0]   clamped_count;

  // Stream handshake, capture of returning read data and FIFO accounting
  assign pop      = head_valid_q & bus.m_ready;
  assign push     = rd_pending_q;
  assign occ_next = {1'b0, head_valid_q} + {1'b0, tail_valid_q}
                  + {1'b0, rd_pending_q} - {1'b0, pop};
  // The word leaving is the only one left anywhere in the pipe
  assign last_pop = pop & ~tail_valid_q & ~rd_pending_q;
  assign clamped_count = (bus.count > MAX_COUNT) ? MAX_COUNT : bus.count;

  // Next-state, read issue and counter updates
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and turn it into a latch.
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_READ;
            addr_d  = bus.base_addr;
            rem_d   = clamped_count;
          end
        end
      end
      ST_READ: begin
        rd_en = (rem_q != '0) && (occ_next < 2'd2);
        if (rd_en) begin
          addr_d = addr_q + ONE_ADDR;
          rem_d  = rem_q - ONE_COUNT;
          if (rem_q == ONE_COUNT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (last_pop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      done_q       <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      done_q       <= done_d;
      rd_pending_q <= rd_en;
    end
  end

  // Output FIFO: append the word returned by last cycle's read, drop the head on handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_valid_q <= 1'b0;
      tail_valid_q <= 1'b0;
      head_data_q  <= '0;
      // NOTE: tail_data_q is deliberately not reset; tail_valid_q qualifies it.
    end else begin
      case ({pop, push})
        2'b01: begin
          if (!head_valid_q) begin
            head_valid_q <= 1'b1;
            head_data_q  <= bus.mem_r_data;
          end else begin
            tail_valid_q <= 1'b1;
            tail_data_q  <= bus.mem_r_data;
          end
        end
        2'b10: begin
          head_valid_q <= tail_valid_q;
          if (tail_valid_q) begin
            head_data_q <= tail_data_q;
          end
          tail_valid_q <= 1'b0;
        end
        2'b11: begin
          if (tail_valid_q) begin
            head_data_q <= tail_data_q;
            tail_data_q <= bus.mem_r_data;
          end else begin
            head_data_q <= bus.mem_r_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: reads are combinational, everything else comes straight from flops
  assign bus.mem_r_en   = rd_en;
  assign bus.mem_r_addr = rd_en ? addr_q : '0;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.m_valid    = head_valid_q;
  assign bus.m_data     = head_data_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: directed timing traces,
// scoreboarded bursts with stalling consumers, reset and start corner cases,
// and randomized bursts compared against a word-list model of the memory.
module tb_mem_stream_reader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DW-1:0] mem [DEPTH];
  int tests = 0;
  int fails = 0;

  // Monitor-owned observations
  logic [DW-1:0] got[$];
  int addr_log[$];
  int done_cnt    = 0;
  int hold_viol   = 0;
  int ovf_viol    = 0;
  int addr0_viol  = 0;
  int outstanding = 0;
  logic          stall_q    = 1'b0;
  logic [DW-1:0] stall_data = '0;

  // Memory model: one-cycle read latency, poison value when not read
  always @(posedge clk) begin
    bus.mem_r_data <= bus.mem_r_en ? mem[bus.mem_r_addr] : 8'hEE;
  end

  // Bus monitor: handshakes, read addresses, done pulses, stall stability, occupancy
  always @(posedge clk) begin
    if (!rst) begin
      outstanding <= 0;
      stall_q     <= 1'b0;
    end else begin
      if (bus.mem_r_en) addr_log.push_back(int'(bus.mem_r_addr));
      else if (bus.mem_r_addr != '0) addr0_viol <= addr0_viol + 1;
      if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
      if (bus.done) done_cnt <= done_cnt + 1;
      if (stall_q && (!bus.m_valid || bus.m_data !== stall_data)) hold_viol <= hold_viol + 1;
      stall_q    <= bus.m_valid && !bus.m_ready;
      stall_data <= bus.m_data;
      if (outstanding + int'(bus.mem_r_en) - int'(bus.m_valid && bus.m_ready) > 2)
        ovf_viol <= ovf_viol + 1;
      outstanding <= outstanding + int'(bus.mem_r_en) - int'(bus.m_valid && bus.m_ready);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Cycle-exact trace with m_ready held high: reads in cycles 1..n,
  // words in cycles 3..n+2, done in cycle n+3 (cycle 1 when n is 0).
  task automatic run_timed(input int b, input int c, input string tag);
    int n;
    logic e_en, e_valid, e_busy, e_done;
    int e_addr;
    n = (c > DEPTH) ? DEPTH : c;
    bus.start     = 1'b1;
    bus.base_addr = AW'(b);
    bus.count     = (AW+1)'(c);
    bus.m_ready   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= n + 4; k++) begin
      e_en    = (k <= n);
      e_addr  = e_en ? (b + k - 1) % DEPTH : 0;
      e_valid = (k >= 3) && (k <= n + 2);
      e_busy  = (n > 0) && (k <= n + 2);
      e_done  = (n == 0) ? (k == 1) : (k == n + 3);
      check({tag, ":mem_r_en"},   bus.mem_r_en,   e_en);
      check({tag, ":mem_r_addr"}, bus.mem_r_addr, e_addr);
      check({tag, ":m_valid"},    bus.m_valid,    e_valid);
      check({tag, ":busy"},       bus.busy,       e_busy);
      check({tag, ":done"},       bus.done,       e_done);
      if (e_valid) check({tag, ":m_data"}, bus.m_data, mem[(b + k - 3) % DEPTH]);
      @(negedge clk);
    end
  endtask

  // Scoreboarded burst: word list, address list, one done pulse, no stall or
  // occupancy violations. A nonzero glitch_cyc injects a start mid-burst.
  task automatic run_sb(input int b, input int c, input int mode, input int glitch_cyc,
                        input string tag);
    int n, g0, a0, d0, hv0, ov0, av0;
    logic seen;
    n   = (c > DEPTH) ? DEPTH : c;
    g0  = got.size();
    a0  = addr_log.size();
    d0  = done_cnt;
    hv0 = hold_viol;
    ov0 = ovf_viol;
    av0 = addr0_viol;
    bus.start     = 1'b1;
    bus.base_addr = AW'(b);
    bus.count     = (AW+1)'(c);
    bus.m_ready   = ready_for(mode, 0);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 300 && !seen; cyc++) begin
      @(negedge clk);
      bus.start = (glitch_cyc != 0) && (cyc == glitch_cyc);
      if (bus.start) begin
        bus.base_addr = AW'(9);
        bus.count     = (AW+1)'(2);
      end
      bus.m_ready = ready_for(mode, cyc);
      seen = bus.done;
    end
    bus.start = 1'b0;
    check({tag, ":done_seen"}, seen, 1'b1);
    @(negedge clk);
    check({tag, ":done_once"}, done_cnt - d0, 1);
    check({tag, ":idle_busy"}, bus.busy, 1'b0);
    check({tag, ":done_low"},  bus.done, 1'b0);
    check({tag, ":nwords"}, got.size() - g0, n);
    for (int i = 0; i < n; i++)
      if (g0 + i < got.size()) check({tag, ":word"}, got[g0 + i], mem[(b + i) % DEPTH]);
    check({tag, ":naddr"}, addr_log.size() - a0, n);
    for (int i = 0; i < n; i++)
      if (a0 + i < addr_log.size()) check({tag, ":addr"}, addr_log[a0 + i], (b + i) % DEPTH);
    check({tag, ":stall_hold"}, hold_viol - hv0, 0);
    check({tag, ":overflow"},   ovf_viol - ov0, 0);
    check({tag, ":addr_idle0"}, addr0_viol - av0, 0);
  endtask

  initial begin
    int g0, d0;
    logic seen;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'hA0 + i);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    bus.m_ready   = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst:busy",       bus.busy,       1'b0);
    check("rst:done",       bus.done,       1'b0);
    check("rst:m_valid",    bus.m_valid,    1'b0);
    check("rst:m_data",     bus.m_data,     8'h00);
    check("rst:mem_r_en",   bus.mem_r_en,   1'b0);
    check("rst:mem_r_addr", bus.mem_r_addr, 4'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed timing traces
    run_timed(2, 4, "base2");
    run_timed(14, 4, "wrap");
    run_timed(0, 0, "zero");
    run_timed(0, 20, "clamp");

    // Full pass with a stalling consumer, then an ignored mid-burst start
    run_sb(0, 16, 1, 0, "toggle");
    run_sb(3, 8, 0, 3, "midstart");

    // Start presented in the done cycle is accepted
    g0 = got.size();
    bus.start = 1'b1; bus.base_addr = AW'(0); bus.count = (AW+1)'(1); bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.done;
    end
    check("chain:done1", seen, 1'b1);
    bus.start = 1'b1; bus.base_addr = AW'(7); bus.count = (AW+1)'(2);
    @(negedge clk);
    bus.start = 1'b0;
    check("chain:busy",     bus.busy,       1'b1);
    check("chain:mem_r_en", bus.mem_r_en,   1'b1);
    check("chain:addr",     bus.mem_r_addr, 4'd7);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.done;
    end
    check("chain:done2", seen, 1'b1);
    @(negedge clk);
    check("chain:nwords", got.size() - g0, 3);
    if (got.size() - g0 == 3) begin
      check("chain:w0", got[g0],     8'hA0);
      check("chain:w1", got[g0 + 1], 8'hA7);
      check("chain:w2", got[g0 + 2], 8'hA8);
    end

    // Reset after two words: no done, clean outputs, fresh burst afterwards
    g0 = got.size();
    d0 = done_cnt;
    bus.start = 1'b1; bus.base_addr = AW'(5); bus.count = (AW+1)'(10); bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = (got.size() - g0) >= 2;
    end
    check("mrst:two_words", seen, 1'b1);
    if (got.size() - g0 >= 2) begin
      check("mrst:w0", got[g0],     8'hA5);
      check("mrst:w1", got[g0 + 1], 8'hA6);
    end
    rst = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("mrst:busy",       bus.busy,       1'b0);
    check("mrst:m_valid",    bus.m_valid,    1'b0);
    check("mrst:done",       bus.done,       1'b0);
    check("mrst:mem_r_en",   bus.mem_r_en,   1'b0);
    check("mrst:mem_r_addr", bus.mem_r_addr, 4'h0);
    check("mrst:m_data",     bus.m_data,     8'h00);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mrst:after_done",  bus.done,    1'b0);
      check("mrst:after_valid", bus.m_valid, 1'b0);
    end
    check("mrst:no_done_pulse", done_cnt - d0, 0);
    run_timed(11, 3, "post_rst");

    // Randomized bursts against the word-list model
    for (int r = 0; r < 10; r++)
      run_sb(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)),
             2, 0, "rand_sb");
    for (int r = 0; r < 3; r++)
      run_timed(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)), "rand_timed");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
